// File: rtl/cp0_regs_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception
// codes, mtc0 writable masks and the default exception vector.
package cp0_regs_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Only the encoder's known codes count as an exception; anything else is idle.
  function automatic logic exc_known(input logic [31:0] t);
    logic k;
    case (t)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV, EXC_ERET: k = 1'b1;
      default:                          k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with the sticky timer-interrupt latch.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we)
        compare <= wdata;
      // A Compare write acknowledges the interrupt and beats a same-cycle match.
      if (compare_we)
        timer_int <= 1'b0;
      else if ((count == compare) && (compare != 32'd0))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: exception bookkeeping, mfc0/mtc0 and flush/redirect.
// Define CP0_TIMER_EN to build in the Count/Compare timer (cp0_timer).
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] exceptionType_i,
  input  logic [31:0] currentPC_i,
  input  logic        isInDelaySlot_i,
  input  logic [31:0] badVAddr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] newPC_o
);

  logic        exc_any;
  logic        is_eret;
  logic        exc_take;
  logic        wr;
  logic [31:0] status_wval;
  logic [31:0] cause_wval;

  assign exc_any  = exc_known(exceptionType_i);
  assign is_eret  = (exceptionType_i == EXC_ERET);
  assign exc_take = exc_any && !is_eret;
  // Any exception, eret included, swallows a coincident mtc0.
  assign wr       = we_i && !exc_any;

  assign status_wval = (wdata_i & STATUS_WMASK) | (status_o & ~STATUS_WMASK);
  assign cause_wval  = (wdata_i & CAUSE_WMASK)  | (cause_o  & ~CAUSE_WMASK);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr && (waddr_i == CP0_COUNT)),
    .compare_we (wr && (waddr_i == CP0_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );
`else
  assign count_o     = 32'd0;
  assign compare_o   = 32'd0;
  assign timer_int_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      status_o <= STATUS_RST;
    else if (exc_take)
      status_o[1] <= 1'b1;
    else if (is_eret)
      status_o[1] <= 1'b0;
    else if (wr && (waddr_i == CP0_STATUS))
      status_o <= status_wval;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_o <= 32'd0;
    end else begin
      cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc_take) begin
        // BD is frozen for nested exceptions, like EPC.
        if (!status_o[1])
          cause_o[31] <= isInDelaySlot_i;
        cause_o[6:2] <= (exceptionType_i == EXC_INT) ? 5'd0 : exceptionType_i[4:0];
      end else if (wr && (waddr_i == CP0_CAUSE)) begin
        cause_o[9:8] <= wdata_i[9:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      epc_o <= 32'd0;
    else if (exc_take && !status_o[1])
      epc_o <= isInDelaySlot_i ? currentPC_i - 32'd4 : currentPC_i;
    else if (wr && (waddr_i == CP0_EPC))
      epc_o <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)
      badvaddr_o <= 32'd0;
    else if (exc_take && ((exceptionType_i == EXC_ADEL) || (exceptionType_i == EXC_ADES)))
      badvaddr_o <= badVAddr_i;
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: data_o = badvaddr_o;
      CP0_COUNT:    data_o = count_o;
      CP0_COMPARE:  data_o = compare_o;
      CP0_STATUS:   data_o = status_o;
      CP0_CAUSE:    data_o = cause_o;
      CP0_EPC:      data_o = epc_o;
      default:      data_o = 32'd0;
    endcase
    // Forward the value the pending mtc0 will actually leave in the register.
    if (wr && (waddr_i == raddr_i)) begin
      case (waddr_i)
        CP0_STATUS: data_o = status_wval;
        CP0_CAUSE:  data_o = cause_wval;
        CP0_EPC:    data_o = wdata_i;
`ifdef CP0_TIMER_EN
        CP0_COUNT:   data_o = wdata_i;
        CP0_COMPARE: data_o = wdata_i;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    flush_o = 1'b0;
    newPC_o = 32'd0;
    if (is_eret) begin
      flush_o = 1'b1;
      newPC_o = epc_o;
    end else if (exc_take) begin
      flush_o = 1'b1;
      newPC_o = EXC_VECTOR;
    end
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Scoreboard bench for cp0_regs: expectations are queued when stimulus is
// driven and compared against the DUT outputs when they become valid.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] wdata_i;
  logic [5:0]  int_i;
  logic [31:0] exceptionType_i;
  logic [31:0] currentPC_i;
  logic        isInDelaySlot_i;
  logic [31:0] badVAddr_i;
  logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, newPC_o;
  logic        timer_int_o, flush_o;

  int chk_cnt = 0;
  int err_cnt = 0;

  typedef enum int {S_DATA, S_STATUS, S_CAUSE, S_EPC, S_COUNT, S_COMPARE,
                    S_BADV, S_FLUSH, S_NEWPC, S_TIMER} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk             (clk),
    .rst             (rst),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .raddr_i         (raddr_i),
    .wdata_i         (wdata_i),
    .int_i           (int_i),
    .exceptionType_i (exceptionType_i),
    .currentPC_i     (currentPC_i),
    .isInDelaySlot_i (isInDelaySlot_i),
    .badVAddr_i      (badVAddr_i),
    .data_o          (data_o),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o),
    .count_o         (count_o),
    .compare_o       (compare_o),
    .badvaddr_o      (badvaddr_o),
    .timer_int_o     (timer_int_o),
    .flush_o         (flush_o),
    .newPC_o         (newPC_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_DATA:    return data_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_BADV:    return badvaddr_o;
      S_FLUSH:   return {31'd0, flush_o};
      S_NEWPC:   return newPC_o;
      default:   return {31'd0, timer_int_o};
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Apply one cycle's inputs on the falling edge.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [31:0] typ,
                       input logic [31:0] pc, input logic ds, input logic [31:0] bva);
    @(negedge clk);
    we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra;
    exceptionType_i = typ; currentPC_i = pc; isInDelaySlot_i = ds; badVAddr_i = bva;
  endtask

  task automatic settle();
    #1 drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; int_i = 6'd0;
    idle();
    tick(); tick();
    expect_val("rst_status", S_STATUS, 32'h0040_0000);
    expect_val("rst_cause", S_CAUSE, 32'h0);
    expect_val("rst_epc", S_EPC, 32'h0);
    expect_val("rst_count", S_COUNT, 32'h0);
    expect_val("rst_compare", S_COMPARE, 32'h0);
    expect_val("rst_badv", S_BADV, 32'h0);
    expect_val("rst_flush", S_FLUSH, 32'h0);
    expect_val("rst_newpc", S_NEWPC, 32'h0);
    expect_val("rst_timer", S_TIMER, 32'h0);
    drain();
    @(negedge clk); rst = 1'b0;

    // Status write mask and forwarding
    drive(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("fwd_status", S_DATA, 32'h0040_FF03);
    settle(); tick();
    expect_val("wr_status", S_STATUS, 32'h0040_FF03);
    drain();
    drive(1'b0, 5'd0, 32'd0, 5'd12, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("rd_status", S_DATA, 32'h0040_FF03);
    settle();
    drive(1'b1, 5'd12, 32'h0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    expect_val("clr_status", S_STATUS, 32'h0040_0000);
    drain();

    // Syscall in a delay slot
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'h8, 32'h8000_0080, 1'b1, 32'd0);
    expect_val("sys_flush", S_FLUSH, 32'h1);
    expect_val("sys_newpc", S_NEWPC, 32'hBFC0_0380);
    settle(); tick();
    expect_val("sys_epc", S_EPC, 32'h8000_007C);
    expect_val("sys_cause", S_CAUSE, 32'h8000_0020);
    expect_val("sys_status", S_STATUS, 32'h0040_0002);
    drain();

    // Nested overflow keeps EPC/BD, then eret
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'hC, 32'h9000_0000, 1'b0, 32'd0);
    expect_val("ov_flush", S_FLUSH, 32'h1);
    settle(); tick();
    expect_val("nest_epc", S_EPC, 32'h8000_007C);
    expect_val("nest_cause", S_CAUSE, 32'h8000_0030);
    drain();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'hE, 32'd0, 1'b0, 32'd0);
    expect_val("eret_flush", S_FLUSH, 32'h1);
    expect_val("eret_newpc", S_NEWPC, 32'h8000_007C);
    settle(); tick();
    expect_val("eret_status", S_STATUS, 32'h0040_0000);
    drain();

    // AdEL with a coincident mtc0 EPC that must be dropped
    drive(1'b1, 5'd14, 32'hDEAD_BEEF, 5'd0, 32'h4, 32'h0000_1000, 1'b0, 32'h1234_5671);
    tick();
    expect_val("adel_badv", S_BADV, 32'h1234_5671);
    expect_val("adel_cause", S_CAUSE, 32'h0000_0010);
    expect_val("adel_epc", S_EPC, 32'h0000_1000);
    drain();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'hE, 32'd0, 1'b0, 32'd0);
    expect_val("eret2_newpc", S_NEWPC, 32'h0000_1000);
    settle(); tick();

    // Interrupt type records ExcCode 0
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'h1, 32'h0000_0100, 1'b0, 32'd0);
    tick();
    expect_val("int_cause", S_CAUSE, 32'h0);
    expect_val("int_epc", S_EPC, 32'h0000_0100);
    drain();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'hE, 32'd0, 1'b0, 32'd0);
    tick();

    // Unrecognised type is not an exception
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'h3, 32'h0000_0200, 1'b0, 32'd0);
    expect_val("unk_flush", S_FLUSH, 32'h0);
    expect_val("unk_newpc", S_NEWPC, 32'h0);
    settle(); tick();
    expect_val("unk_status", S_STATUS, 32'h0040_0000);
    expect_val("unk_epc", S_EPC, 32'h0000_0100);
    drain();

    // Cause write mask, BadVAddr read-only, EPC write, unmapped read
    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("fwd_cause", S_DATA, 32'h0000_0300);
    settle(); tick();
    expect_val("wr_cause", S_CAUSE, 32'h0000_0300);
    drain();
    drive(1'b1, 5'd8, 32'h0, 5'd8, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("fwd_badv", S_DATA, 32'h1234_5671);
    settle(); tick();
    expect_val("ro_badv", S_BADV, 32'h1234_5671);
    drain();
    drive(1'b1, 5'd14, 32'hA5A5_0000, 5'd5, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("rd_unmapped", S_DATA, 32'h0);
    settle(); tick();
    expect_val("wr_epc", S_EPC, 32'hA5A5_0000);
    drain();

    // Hardware interrupt lines sampled into Cause
    idle(); int_i = 6'b100001;
    tick();
    expect_val("hw_int_cause", S_CAUSE, 32'h0000_8700);
    drain();
    idle(); int_i = 6'd0;
    tick();
    expect_val("hw_int_clr", S_CAUSE, 32'h0000_0300);
    drain();

`ifdef CP0_TIMER_EN
    drive(1'b1, 5'd11, 32'h5, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    expect_val("tmr_compare", S_COMPARE, 32'h5);
    drain();
    drive(1'b1, 5'd9, 32'h0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    expect_val("tmr_count0", S_COUNT, 32'h0);
    drain();
    for (int i = 1; i <= 5; i++) begin
      idle(); tick();
    end
    expect_val("tmr_count5", S_COUNT, 32'h5);
    expect_val("tmr_pre", S_TIMER, 32'h0);
    drain();
    idle(); tick();
    expect_val("tmr_set", S_TIMER, 32'h1);
    expect_val("tmr_count6", S_COUNT, 32'h6);
    drain();
    idle(); tick();
    expect_val("tmr_cause15", S_CAUSE, 32'h0000_8300);
    drain();
    drive(1'b1, 5'd11, 32'h100, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    expect_val("tmr_clr", S_TIMER, 32'h0);
    drain();
`else
    drive(1'b1, 5'd11, 32'h5, 5'd11, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_val("notmr_fwd", S_DATA, 32'h0);
    settle(); tick();
    expect_val("notmr_compare", S_COMPARE, 32'h0);
    drain();
    for (int i = 0; i < 8; i++) begin
      idle(); tick();
    end
    expect_val("notmr_count", S_COUNT, 32'h0);
    expect_val("notmr_timer", S_TIMER, 32'h0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
